// File: rtl/multiplexer_nto1_stream_pkg.sv
// Shared definitions for the N:1 registered stream multiplexer:
// mode encoding, default sizing and a pointer-wrap helper.
package multiplexer_nto1_stream_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_SCAN  = 1'b1
  } mode_e;

  localparam int unsigned DEFAULT_WIDTH    = 5;
  localparam int unsigned DEFAULT_CHANNELS = 4;
  localparam int unsigned DEFAULT_SEL_W    = 2;

  // Index after idx in a ring of n channels.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/multiplexer_nto1_stream_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// searching from ptr upward, wrapping modulo CHANNELS.
module rr_arbiter #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  input  logic                en,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                any_grant
);

  always_comb begin
    int unsigned c;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    c         = 0;
    if (en) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        c = (int'(ptr) + k) % CHANNELS;
        if (!any_grant && req[c]) begin
          any_grant = 1'b1;
          grant[c]  = 1'b1;
          grant_idx = SEL_W'(c);
        end
      end
    end
  end

endmodule

// File: rtl/multiplexer_nto1_stream.sv
// Registered N:1 stream multiplexer with valid/ready on every channel.
// Fixed mode follows select; scan mode round-robins over valid channels.
module multiplexer_nto1_stream
  import multiplexer_nto1_stream_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned CHANNELS = DEFAULT_CHANNELS,
  parameter int unsigned SEL_W    = DEFAULT_SEL_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  output logic [WIDTH-1:0]          channel_out,
  output logic [SEL_W-1:0]          channel_id,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0]    r_channel_out;
  logic [SEL_W-1:0]    r_channel_id;
  logic                r_out_valid;
  logic [SEL_W-1:0]    r_rr_ptr;

  logic                w_scan;
  logic                w_load_en;
  logic [CHANNELS-1:0] w_fix_grant;
  logic [SEL_W-1:0]    w_fix_idx;
  logic                w_fix_any;
  logic [CHANNELS-1:0] w_arb_grant;
  logic [SEL_W-1:0]    w_arb_idx;
  logic                w_arb_any;
  logic [CHANNELS-1:0] w_grant;
  logic [SEL_W-1:0]    w_grant_idx;
  logic                w_any;
  logic                w_xfer;
  logic [WIDTH-1:0]    w_data;

  assign w_scan    = (mode == MODE_SCAN);
  assign w_load_en = !r_out_valid || out_ready;

  // A select value beyond CHANNELS-1 matches no channel, so nothing is granted.
  always_comb begin
    w_fix_grant = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (int'(select) == i) begin
        w_fix_grant[i] = in_valid[i];
      end
    end
  end
  assign w_fix_idx = select;
  assign w_fix_any = |w_fix_grant;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (r_rr_ptr),
    .en        (w_scan),
    .grant     (w_arb_grant),
    .grant_idx (w_arb_idx),
    .any_grant (w_arb_any)
  );

  assign w_grant     = w_scan ? w_arb_grant : w_fix_grant;
  assign w_grant_idx = w_scan ? w_arb_idx   : w_fix_idx;
  assign w_any       = w_scan ? w_arb_any   : w_fix_any;

  assign in_ready = (rst_n && w_load_en) ? w_grant : '0;
  assign w_xfer   = w_load_en && w_any;

  always_comb begin
    w_data = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      w_data = w_data | (in_bus[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_channel_out <= '0;
      r_channel_id  <= '0;
      r_out_valid   <= 1'b0;
      r_rr_ptr      <= '0;
    end else if (w_xfer) begin
      r_channel_out <= w_data;
      r_channel_id  <= w_grant_idx;
      r_out_valid   <= 1'b1;
      if (w_scan) begin
        r_rr_ptr <= SEL_W'(wrap_inc(int'(w_grant_idx), CHANNELS));
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign channel_out = r_channel_out;
  assign channel_id  = r_channel_id;
  assign out_valid   = r_out_valid;

endmodule

// File: tb/tb_multiplexer_nto1_stream.sv
// Directed bench for multiplexer_nto1_stream (WIDTH=5, CHANNELS=4).
module tb_multiplexer_nto1_stream;

  localparam int W  = 5;
  localparam int CH = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH*W-1:0] in_bus;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic            mode;
  logic [SW-1:0]   select;
  logic [W-1:0]    channel_out;
  logic [SW-1:0]   channel_id;
  logic            out_valid;
  logic            out_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  multiplexer_nto1_stream #(
    .WIDTH    (W),
    .CHANNELS (CH),
    .SEL_W    (SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_bus      (in_bus),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mode        (mode),
    .select      (select),
    .channel_out (channel_out),
    .channel_id  (channel_id),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] d, input logic [SW-1:0] id,
                         input logic v);
    chk({tag, ".data"}, 32'(channel_out), 32'(d));
    chk({tag, ".id"}, 32'(channel_id), 32'(id));
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
  endtask

  task automatic set_bus(input logic [W-1:0] c3, input logic [W-1:0] c2,
                         input logic [W-1:0] c1, input logic [W-1:0] c0);
    in_bus = {c3, c2, c1, c0};
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 4'b0000;
    mode      = 1'b0;
    select    = 2'd0;
    out_ready = 1'b0;
    set_bus(5'd0, 5'd0, 5'd0, 5'd0);

    // 1. Reset asserted mid-cycle, then fixed-mode transfer.
    #3;
    rst_n    = 1'b0;
    in_valid = 4'b1111;
    #1;
    chk_out("reset_async", 5'b00000, 2'd0, 1'b0);
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    tick();
    tick();
    #2;
    rst_n    = 1'b1;
    in_valid = 4'b0000;
    tick();
    chk_out("post_release", 5'b00000, 2'd0, 1'b0);

    mode      = 1'b0;
    select    = 2'd2;
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    set_bus(5'd0, 5'b10011, 5'd0, 5'd0);
    #1;
    chk("fixed_in_ready", 32'(in_ready), 32'b0100);
    tick();
    chk_out("fixed_load", 5'b10011, 2'd2, 1'b1);

    // 2. Back-pressure for 3 cycles, then drain and load on the same edge.
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    set_bus(5'd4, 5'b01010, 5'd2, 5'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'h0);
      tick();
      chk_out("stall_hold", 5'b10011, 2'd2, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 32'(in_ready), 32'b0100);
    tick();
    chk_out("unstall_load", 5'b01010, 2'd2, 1'b1);

    // 3. Round-robin fairness; pointer is still 0 after fixed-mode transfers.
    mode = 1'b1;
    set_bus(5'd4, 5'd3, 5'd2, 5'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("rr_seq", W'((i % 4) + 1), SW'(i % 4), 1'b1);
    end

    // 4. Skip and wrap: pointer now 1; ch2 moves it to 3.
    in_valid = 4'b0100;
    tick();
    chk_out("scan_ch2", 5'd3, 2'd2, 1'b1);
    in_valid = 4'b0010;
    #1;
    chk("skip_in_ready", 32'(in_ready), 32'b0010);
    tick();
    chk_out("skip_to_ch1", 5'd2, 2'd1, 1'b1);
    in_valid = 4'b1001;
    tick();
    chk_out("wrap_ch3", 5'd4, 2'd3, 1'b1);
    tick();
    chk_out("wrap_ch0", 5'd1, 2'd0, 1'b1);

    // 5. Fixed select on an invalid channel, then scan with nothing valid.
    mode     = 1'b0;
    select   = 2'd1;
    in_valid = 4'b1101;
    #1;
    chk("fixed_invalid_ready", 32'(in_ready), 32'h0);
    tick();
    chk_out("fixed_invalid_drain", 5'd1, 2'd0, 1'b0);
    mode     = 1'b1;
    in_valid = 4'b0000;
    #1;
    chk("scan_empty_ready", 32'(in_ready), 32'h0);
    tick();
    chk_out("scan_empty", 5'd1, 2'd0, 1'b0);

    // 6. Reset while a word is held under stall; pointer returns to 0.
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    tick();
    chk_out("pre_reset_load", 5'd3, 2'd2, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("mid_reset", 5'd0, 2'd0, 1'b0);
    chk("mid_reset_ready", 32'(in_ready), 32'h0);
    tick();
    #2;
    rst_n     = 1'b1;
    in_valid  = 4'b1010;
    out_ready = 1'b1;
    #1;
    chk("post_reset_ready", 32'(in_ready), 32'b0010);
    tick();
    chk_out("post_reset_grant", 5'd2, 2'd1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
